// File: rtl/uart_rx_fifo.sv
// UART receiver with majority-vote oversampling, parity/framing/break
// detection and a small receive FIFO holding {frm_err, par_err, data}.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 9,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          RX_IN,
    input  logic [5:0]                    Prescale,
    input  logic [3:0]                    data_len,
    input  logic                          parity_enable,
    input  logic                          parity_type,
    input  logic                          stop_bits,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_par_err,
    output logic                          rd_frm_err,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic                          break_det
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_WIDTH + 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } state_t;

    state_t state, state_next;

    logic                  rx_meta, rx_sync;
    logic [5:0]            edge_cnt;
    logic [3:0]            bit_cnt;
    logic [5:0]            cfg_p;
    logic [3:0]            cfg_len;
    logic                  cfg_par_en, cfg_par_odd, cfg_two_stop;
    logic                  samp_a, samp_b;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  par_bit, all_zero, frm_err_r;
    logic                  push_pending;
    logic [EW-1:0]         push_data;

    logic [5:0]            eff_p, half;
    logic [3:0]            len_clamp;
    logic                  at_sample_a, at_sample_b, at_decide, at_wrap;
    logic                  maj, last_data, last_stop, break_hit, push_now;
    logic                  frm_err_final, par_err_final;

    logic [EW-1:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [EW-1:0]         head;
    logic                  fifo_full, do_pop, do_write;

    // Unsupported oversampling ratios fall back to 16; data length is clamped.
    always_comb begin
        eff_p = 6'd16;
        case (Prescale)
            6'd8:    eff_p = 6'd8;
            6'd16:   eff_p = 6'd16;
            6'd32:   eff_p = 6'd32;
            default: eff_p = 6'd16;
        endcase
        len_clamp = data_len;
        if (data_len < 4'd5)
            len_clamp = 4'd5;
        else if (data_len > 4'(DATA_WIDTH))
            len_clamp = 4'(DATA_WIDTH);
    end

    assign half          = {1'b0, cfg_p[5:1]};
    assign at_sample_a   = (edge_cnt == half - 6'd1);
    assign at_sample_b   = (edge_cnt == half);
    assign at_decide     = (edge_cnt == half + 6'd1);
    assign at_wrap       = (edge_cnt == cfg_p - 6'd1);
    assign maj           = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);
    assign last_data     = (bit_cnt == cfg_len - 4'd1);
    assign last_stop     = (bit_cnt == {3'b000, cfg_two_stop});
    assign break_hit     = (state == STOP) && at_decide && (bit_cnt == 4'd0) && all_zero && !maj;
    assign push_now      = (state == STOP) && at_decide && (break_hit || last_stop);
    assign frm_err_final = frm_err_r | ~maj;
    assign par_err_final = cfg_par_en & ((^data_reg ^ par_bit) != cfg_par_odd);

    // Two-flop synchroniser for the asynchronous serial line, idling high.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= RX_IN;
            rx_sync <= rx_meta;
        end
    end

    // Receiver state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic: bit boundaries at edge-counter wrap, decisions mid-bit.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (!rx_sync) state_next = START;
            START: begin
                if (at_decide && maj)
                    state_next = IDLE;
                else if (at_wrap)
                    state_next = DATA;
            end
            DATA:     if (at_wrap && last_data) state_next = cfg_par_en ? PARITY : STOP;
            PARITY:   if (at_wrap) state_next = STOP;
            STOP: begin
                if (break_hit)
                    state_next = BRK_WAIT;
                else if (at_decide && last_stop)
                    state_next = IDLE;
            end
            BRK_WAIT: if (rx_sync) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Edge counter spans one bit period; bit counter restarts on every state change.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt <= 6'd0;
            bit_cnt  <= 4'd0;
        end else begin
            if (state == IDLE || state_next == IDLE || state_next == BRK_WAIT || at_wrap)
                edge_cnt <= 6'd0;
            else
                edge_cnt <= edge_cnt + 6'd1;
            if (state_next != state)
                bit_cnt <= 4'd0;
            else if ((state == DATA || state == STOP) && at_wrap)
                bit_cnt <= bit_cnt + 4'd1;
        end
    end

    // Frame configuration is frozen when a start bit is seen.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cfg_p        <= 6'd16;
            cfg_len      <= 4'd8;
            cfg_par_en   <= 1'b0;
            cfg_par_odd  <= 1'b0;
            cfg_two_stop <= 1'b0;
        end else if (state == IDLE && state_next == START) begin
            cfg_p        <= eff_p;
            cfg_len      <= len_clamp;
            cfg_par_en   <= parity_enable;
            cfg_par_odd  <= parity_type;
            cfg_two_stop <= stop_bits;
        end
    end

    // Mid-bit sampling and per-bit capture of data, parity and stop results.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            samp_a    <= 1'b1;
            samp_b    <= 1'b1;
            data_reg  <= '0;
            par_bit   <= 1'b0;
            all_zero  <= 1'b1;
            frm_err_r <= 1'b0;
        end else begin
            if (at_sample_a)
                samp_a <= rx_sync;
            if (at_sample_b)
                samp_b <= rx_sync;
            if (state == IDLE && state_next == START) begin
                data_reg  <= '0;
                par_bit   <= 1'b0;
                all_zero  <= 1'b1;
                frm_err_r <= 1'b0;
            end else if (at_decide) begin
                case (state)
                    DATA: begin
                        data_reg <= data_reg | (DATA_WIDTH'(maj) << bit_cnt);
                        if (maj)
                            all_zero <= 1'b0;
                    end
                    PARITY: begin
                        par_bit <= maj;
                        if (maj)
                            all_zero <= 1'b0;
                    end
                    STOP: if (!maj) frm_err_r <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Completed frames are handed to the FIFO one cycle after the final decision.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            push_pending <= 1'b0;
            push_data    <= '0;
            break_det    <= 1'b0;
        end else begin
            push_pending <= push_now;
            break_det    <= break_hit;
            if (push_now)
                push_data <= {frm_err_final, par_err_final, data_reg};
        end
    end

    assign rd_valid   = (fifo_count != '0);
    assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
    assign do_pop     = rd_valid && rd_ready;
    assign do_write   = push_pending && (!fifo_full || do_pop);
    assign head       = mem[rd_ptr];
    assign rd_data    = rd_valid ? head[DATA_WIDTH-1:0] : '0;
    assign rd_par_err = rd_valid & head[DATA_WIDTH];
    assign rd_frm_err = rd_valid & head[DATA_WIDTH+1];

    // FIFO pointers, occupancy and the sticky overflow flag (set beats clear).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (do_write)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_write, do_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
            if (push_pending && fifo_full && !do_pop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    // Entry storage; contents are qualified by occupancy so no reset is needed.
    always_ff @(posedge CLK) begin
        if (do_write)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo: one task per scenario.
module tb_uart_rx_fifo;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd16;
    logic [3:0] data_len = 4'd8;
    logic       parity_enable = 1'b0;
    logic       parity_type = 1'b0;
    logic       stop_bits = 1'b0;
    logic [8:0] rd_data;
    logic       rd_par_err, rd_frm_err, rd_valid;
    logic       rd_ready = 1'b0;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       ovf_clr = 1'b0;
    logic       break_det;

    int n_checks = 0;
    int n_fail = 0;
    int brk_pulses = 0;

    uart_rx_fifo #(.DATA_WIDTH(9), .FIFO_DEPTH(8)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .data_len(data_len),
        .parity_enable(parity_enable), .parity_type(parity_type), .stop_bits(stop_bits),
        .rd_data(rd_data), .rd_par_err(rd_par_err), .rd_frm_err(rd_frm_err),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .fifo_count(fifo_count),
        .overflow(overflow), .ovf_clr(ovf_clr), .break_det(break_det)
    );

    // 10 ns clock.
    always #5 CLK = ~CLK;

    // Count break pulses away from the active edge.
    always @(negedge CLK) if (break_det) brk_pulses++;

    task automatic set_cfg(input logic [5:0] p, input logic [3:0] len, input logic pe,
                           input logic pt, input logic sb);
        Prescale = p; data_len = len; parity_enable = pe; parity_type = pt; stop_bits = sb;
    endtask

    // Drives one frame, P clocks per bit. With pop_at_push, rd_ready is raised for
    // exactly the cycle in which the received frame is written into the FIFO.
    task automatic send_frame(input int p, input logic [8:0] data, input int len,
                              input logic par_en, input logic par_bit, input logic stop0,
                              input logic stop1, input logic two_stop, input logic pop_at_push);
        @(posedge CLK); #1 RX_IN = 1'b0;
        repeat (p) @(posedge CLK);
        for (int i = 0; i < len; i++) begin
            #1 RX_IN = data[i];
            repeat (p) @(posedge CLK);
        end
        if (par_en) begin
            #1 RX_IN = par_bit;
            repeat (p) @(posedge CLK);
        end
        #1 RX_IN = stop0;
        if (pop_at_push) begin
            repeat (p / 2 + 5) @(posedge CLK);
            #1 rd_ready = 1'b1;
            @(posedge CLK);
            #1 rd_ready = 1'b0;
            repeat (p - p / 2 - 6) @(posedge CLK);
        end else begin
            repeat (p) @(posedge CLK);
        end
        if (two_stop) begin
            #1 RX_IN = stop1;
            repeat (p) @(posedge CLK);
        end
        #1 RX_IN = 1'b1;
    endtask

    task automatic pop_one();
        @(negedge CLK) rd_ready = 1'b1;
        @(negedge CLK) rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", rd_valid); end
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", fifo_count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        n_checks++; if (break_det !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_break: got %b expected 0", break_det); end
        n_checks++; if ({rd_frm_err, rd_par_err, rd_data} !== 11'h000) begin n_fail++; $display("[TB] FAIL reset_rd: got %h expected 000", {rd_frm_err, rd_par_err, rd_data}); end
        RST = 1'b0;
        repeat (20) @(negedge CLK);
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_valid: got %b expected 0", rd_valid); end
    endtask

    task automatic test_basic();
        set_cfg(6'd16, 4'd8, 1'b1, 1'b0, 1'b0);
        send_frame(16, 9'h0A5, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge CLK);
        n_checks++; if (rd_data !== 9'h0A5) begin n_fail++; $display("[TB] FAIL basic_data: got %h expected 0a5", rd_data); end
        n_checks++; if ({rd_frm_err, rd_par_err} !== 2'b00) begin n_fail++; $display("[TB] FAIL basic_flags: got %b expected 00", {rd_frm_err, rd_par_err}); end
        n_checks++; if (fifo_count !== 4'd1) begin n_fail++; $display("[TB] FAIL basic_count: got %0d expected 1", fifo_count); end
        pop_one();
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("[TB] FAIL basic_pop: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_parity_framing();
        // 0x55 in 7 bits has four ones, so odd parity needs 1; send 0 and a bad second stop
        set_cfg(6'd8, 4'd7, 1'b1, 1'b1, 1'b1);
        send_frame(8, 9'h055, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (10) @(negedge CLK);
        n_checks++; if (rd_data !== 9'h055) begin n_fail++; $display("[TB] FAIL perr_data: got %h expected 055", rd_data); end
        n_checks++; if (rd_par_err !== 1'b1) begin n_fail++; $display("[TB] FAIL perr_par: got %b expected 1", rd_par_err); end
        n_checks++; if (rd_frm_err !== 1'b1) begin n_fail++; $display("[TB] FAIL perr_frm: got %b expected 1", rd_frm_err); end
        pop_one();
    endtask

    task automatic test_glitch();
        set_cfg(6'd16, 4'd8, 1'b0, 1'b0, 1'b0);
        @(posedge CLK); #1 RX_IN = 1'b0;
        repeat (5) @(posedge CLK);
        #1 RX_IN = 1'b1;
        repeat (60) @(negedge CLK);
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("[TB] FAIL glitch_count: got %0d expected 0", fifo_count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL glitch_ovf: got %b expected 0", overflow); end
        send_frame(16, 9'h0E1, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge CLK);
        n_checks++; if ({fifo_count, rd_data} !== {4'd1, 9'h0E1}) begin n_fail++; $display("[TB] FAIL glitch_after: got %0d/%h expected 1/0e1", fifo_count, rd_data); end
        pop_one();
    endtask

    task automatic test_config_limits();
        // Prescale 20 behaves as 16; data_len 15 clamps to 9
        set_cfg(6'd20, 4'd15, 1'b0, 1'b0, 1'b0);
        send_frame(16, 9'h1AB, 9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge CLK);
        n_checks++; if (rd_data !== 9'h1AB) begin n_fail++; $display("[TB] FAIL clamp_hi: got %h expected 1ab", rd_data); end
        pop_one();
        // data_len 2 clamps to 5; upper stored bits must be zero
        set_cfg(6'd32, 4'd2, 1'b0, 1'b0, 1'b0);
        send_frame(32, 9'h1F6, 5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge CLK);
        n_checks++; if (rd_data !== 9'h016) begin n_fail++; $display("[TB] FAIL clamp_lo: got %h expected 016", rd_data); end
        pop_one();
    endtask

    task automatic test_overflow();
        set_cfg(6'd16, 4'd8, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++)
            send_frame(16, 9'(i * 17), 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge CLK);
        n_checks++; if (fifo_count !== 4'd8) begin n_fail++; $display("[TB] FAIL ovf_count: got %0d expected 8", fifo_count); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflow); end
        n_checks++; if (rd_data !== 9'h011) begin n_fail++; $display("[TB] FAIL ovf_head: got %h expected 011", rd_data); end
        @(negedge CLK) ovf_clr = 1'b1;
        @(negedge CLK) ovf_clr = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_clr: got %b expected 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [8:0] exp_data;
        send_frame(16, 9'h0C3, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (10) @(negedge CLK);
        n_checks++; if (fifo_count !== 4'd8) begin n_fail++; $display("[TB] FAIL pp_count: got %0d expected 8", fifo_count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL pp_ovf: got %b expected 0", overflow); end
        for (int i = 0; i < 8; i++) begin
            exp_data = (i < 7) ? 9'((i + 2) * 17) : 9'h0C3;
            @(negedge CLK);
            n_checks++; if (rd_data !== exp_data) begin n_fail++; $display("[TB] FAIL pp_drain%0d: got %h expected %h", i, rd_data, exp_data); end
            pop_one();
        end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL pp_empty: got %b expected 0", rd_valid); end
    endtask

    task automatic test_break();
        int start_pulses;
        start_pulses = brk_pulses;
        set_cfg(6'd16, 4'd8, 1'b0, 1'b0, 1'b0);
        @(posedge CLK); #1 RX_IN = 1'b0;
        repeat (320) @(posedge CLK);
        #1 RX_IN = 1'b1;
        repeat (40) @(negedge CLK);
        n_checks++; if (fifo_count !== 4'd1) begin n_fail++; $display("[TB] FAIL brk_count: got %0d expected 1", fifo_count); end
        n_checks++; if (rd_data !== 9'h000) begin n_fail++; $display("[TB] FAIL brk_data: got %h expected 000", rd_data); end
        n_checks++; if (rd_frm_err !== 1'b1) begin n_fail++; $display("[TB] FAIL brk_frm: got %b expected 1", rd_frm_err); end
        n_checks++; if (brk_pulses - start_pulses !== 1) begin n_fail++; $display("[TB] FAIL brk_pulses: got %0d expected 1", brk_pulses - start_pulses); end
        pop_one();
        send_frame(16, 9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge CLK);
        n_checks++; if ({fifo_count, rd_frm_err, rd_data} !== {4'd1, 1'b0, 9'h03C}) begin n_fail++; $display("[TB] FAIL brk_next: got %0d/%b/%h expected 1/0/03c", fifo_count, rd_frm_err, rd_data); end
        pop_one();
    endtask

    task automatic test_reset_mid_frame();
        set_cfg(6'd16, 4'd8, 1'b0, 1'b0, 1'b0);
        @(posedge CLK); #1 RX_IN = 1'b0;
        repeat (16) @(posedge CLK);
        #1 RX_IN = 1'b1;
        repeat (40) @(posedge CLK);
        #1 RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        repeat (200) @(negedge CLK);
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("[TB] FAIL rstmid_count: got %0d expected 0", fifo_count); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_valid: got %b expected 0", rd_valid); end
        send_frame(16, 9'h096, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge CLK);
        n_checks++; if ({fifo_count, rd_data} !== {4'd1, 9'h096}) begin n_fail++; $display("[TB] FAIL rstmid_next: got %0d/%h expected 1/096", fifo_count, rd_data); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity_framing();
        test_glitch();
        test_config_limits();
        test_overflow();
        test_full_push_pop();
        test_break();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 9, the maximum data bits per frame (legal 5..9).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, the receive-buffer entries (power of 2, >= 2).
REQ-003 CLK  input  1  single clock for all logic.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 RX_IN  input  1  serial line, idle high, asynchronous to CLK.
REQ-006 Prescale  input  6  oversampling ratio; legal values 8, 16, 32; any other value SHALL be treated as 16.
REQ-007 data_len  input  4  data bits per frame, 5..DATA_WIDTH; values outside this range SHALL clamp to the nearest limit.
REQ-008 parity_enable  input  1  1 = a parity bit follows the data bits.
REQ-009 parity_type  input  1  0 = even parity, 1 = odd parity.
REQ-010 stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
REQ-011 rd_data  output  DATA_WIDTH  data at the FIFO head, LSB = first received bit.
REQ-012 rd_par_err / rd_frm_err  output  1 each  error flags stored with the head entry.
REQ-013 rd_valid  output  1  FIFO not empty.
REQ-014 rd_ready  input  1  consumer accepts the head entry.
REQ-015 fifo_count  output  clog2(FIFO_DEPTH)+1  number of occupied entries.
REQ-016 overflow  output  1  sticky flag: a frame was dropped.
REQ-017 ovf_clr  input  1  clears overflow.
REQ-018 break_det  output  1  one-cycle pulse when a break condition is detected.

Function
REQ-019 RX_IN SHALL pass through a 2-flop synchroniser (both flops reset to 1); all later references to the line mean the synchronised value.
REQ-020 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
REQ-021 Per bit, an edge counter SHALL run 0..P-1, where P is the effective Prescale; a bit counter SHALL advance when the edge counter wraps.
REQ-022 Samples SHALL be taken at edges P/2-1, P/2 and P/2+1; the bit value SHALL be the 2-of-3 majority, registered at edge P/2+1.
REQ-023 In IDLE, a synchronised 0 SHALL move the FSM to START with the edge counter at 0.
REQ-024 On START entry, Prescale, data_len, parity_enable, parity_type and stop_bits SHALL be latched; input changes during the frame SHALL be ignored.
REQ-025 START: if the majority sample is 1 (glitch), the FSM SHALL return to IDLE at the next cycle, and nothing SHALL be pushed or flagged.
REQ-026 DATA: data_len bits SHALL be shifted in LSB first; bits data_len..DATA_WIDTH-1 of the stored word SHALL be 0.
REQ-027 PARITY (only when parity_enable=1): par_err SHALL equal (XOR of data bits XOR parity bit) != parity_type.
REQ-028 STOP: stop_bits+1 stop bits SHALL be sampled; frm_err SHALL be set if any stop sample is 0.
REQ-029 The FIFO push SHALL occur the cycle after the final stop-bit majority decision; the FSM SHALL then enter IDLE at that cycle, without waiting for the bit period to end.
REQ-030 Break: if all data bits, the parity bit (if enabled) and the first stop sample are all 0, the entry SHALL be pushed with frm_err=1, break_det SHALL pulse, and the FSM SHALL enter BRK_WAIT until the line reads 1, then enter IDLE.
REQ-031 The FIFO SHALL store {frm_err, par_err, data}; rd_* SHALL present the head entry combinationally from storage.
REQ-032 A pop SHALL occur when rd_valid and rd_ready are both 1; a pop while empty SHALL have no effect.
REQ-033 Push while full without a same-cycle pop: the frame SHALL be dropped, overflow SHALL be set, and FIFO contents SHALL be unchanged.
REQ-034 Push and pop in the same cycle (including when full): both SHALL occur, fifo_count SHALL be unchanged, and overflow SHALL not be set.
REQ-035 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-036 ovf_clr SHALL clear overflow; if ovf_clr and a new overflow occur in the same cycle, set SHALL win.

Reset
REQ-037 While RST=1: FSM in IDLE, all counters 0, FIFO empty, rd_valid=0, fifo_count=0, overflow=0, break_det=0, rd_data/rd_par_err/rd_frm_err=0.
REQ-038 RST asserted mid-frame SHALL abort the frame without a push; after release, the receiver SHALL wait for a new falling edge.

Verification
REQ-039 Prescale=16, data_len=8, even parity, 1 stop, frame 0xA5 -> one entry, rd_data=0x0A5, both error flags 0, fifo_count=1.
REQ-040 Prescale=8, data_len=7, odd parity, 2 stops, 0x55 sent with wrong parity and second stop=0 -> entry 0x055, rd_par_err=1, rd_frm_err=1.
REQ-041 A 0.3-bit low pulse on an idle line -> no push, FSM back in IDLE, fifo_count=0.
REQ-042 FIFO_DEPTH=8, rd_ready=0, 9 frames -> fifo_count=8, overflow=1, head still holds frame 1; ovf_clr pulse -> overflow=0.
REQ-043 Line held low for 2 frame times -> exactly one entry 0x000 with rd_frm_err=1, one break_det pulse, next valid frame after line-high received correctly.
REQ-044 Full FIFO, rd_ready=1 in the push cycle -> fifo_count stays 8, overflow=0; RST mid-data-bit -> fifo_count=0 and no partial entry.
